// File: rtl/contador_tempo_bcd.sv
// Microwave MM:SS BCD countdown timer: keypad entry, 1 s decrement while enabled, tdone at 00:00.
// Latency: digits/state update on the clock edge after the input; zero is combinational from the count.
// Backpressure: none; digit strobes outside ENTRY/DONE are dropped.
module contador_tempo_bcd #(
  parameter int TICK_DIV = 50_000_000,
  parameter int PRESC_W  = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       digit_valid,
  input  logic [3:0] digit,
  input  logic       limpa,
  input  logic       enable,
  output logic [3:0] min_dez,
  output logic [3:0] min_uni,
  output logic [3:0] seg_dez,
  output logic [3:0] seg_uni,
  output logic       zero,
  output logic       rodando,
  output logic       tdone
);

  typedef enum logic [1:0] {ENTRY, RUN, PAUSE, DONE} state_t;

  localparam logic [PRESC_W-1:0] TERM = PRESC_W'(TICK_DIV - 1);

  state_t             state, state_nxt;
  logic [15:0]        cnt, cnt_nxt, cnt_dec;
  logic [PRESC_W-1:0] presc, presc_nxt;
  logic               tdone_nxt;
  logic               digit_ok;

  assign cnt      = {min_dez, min_uni, seg_dez, seg_uni};
  assign zero     = (cnt == 16'h0000);
  assign digit_ok = digit_valid && (digit <= 4'd9);

  // BCD one-second borrow chain; a seconds-tens borrow always reloads 5
  always_comb begin
    cnt_dec = cnt;
    if (seg_uni != 4'd0) begin
      cnt_dec[3:0] = seg_uni - 4'd1;
    end else begin
      cnt_dec[3:0] = 4'd9;
      if (seg_dez != 4'd0) begin
        cnt_dec[7:4] = seg_dez - 4'd1;
      end else begin
        cnt_dec[7:4] = 4'd5;
        if (min_uni != 4'd0) begin
          cnt_dec[11:8] = min_uni - 4'd1;
        end else begin
          cnt_dec[11:8]  = 4'd9;
          cnt_dec[15:12] = min_dez - 4'd1;
        end
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    presc_nxt = presc;
    tdone_nxt = tdone;
    if (limpa) begin
      state_nxt = ENTRY;
      cnt_nxt   = 16'h0000;
      presc_nxt = '0;
      tdone_nxt = 1'b0;
    end else begin
      unique case (state)
        ENTRY: begin
          if (digit_ok) cnt_nxt = {cnt[11:0], digit};
          // start decision uses the count before any same-cycle shift
          if (enable && !zero) begin
            state_nxt = RUN;
            presc_nxt = '0;
          end
        end
        RUN, PAUSE: begin
          if (!enable) begin
            state_nxt = PAUSE;
          end else if (presc == TERM) begin
            presc_nxt = '0;
            cnt_nxt   = cnt_dec;
            if (cnt_dec == 16'h0000) begin
              state_nxt = DONE;
              tdone_nxt = 1'b1;
            end else begin
              state_nxt = RUN;
            end
          end else begin
            presc_nxt = presc + 1'b1;
            state_nxt = RUN;
          end
        end
        DONE: begin
          if (digit_ok) begin
            state_nxt = ENTRY;
            cnt_nxt   = {12'h000, digit};
            tdone_nxt = 1'b0;
          end
        end
        default: state_nxt = ENTRY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ENTRY;
      min_dez <= 4'd0;
      min_uni <= 4'd0;
      seg_dez <= 4'd0;
      seg_uni <= 4'd0;
      presc   <= '0;
      tdone   <= 1'b0;
      rodando <= 1'b0;
    end else begin
      state   <= state_nxt;
      min_dez <= cnt_nxt[15:12];
      min_uni <= cnt_nxt[11:8];
      seg_dez <= cnt_nxt[7:4];
      seg_uni <= cnt_nxt[3:0];
      presc   <= presc_nxt;
      tdone   <= tdone_nxt;
      rodando <= (state_nxt == RUN);
    end
  end

endmodule

// File: tb/tb_contador_tempo_bcd.sv
// Directed bench for contador_tempo_bcd with TICK_DIV=4; expectations are queued and checked by a monitor.
module tb_contador_tempo_bcd;

  logic       clk = 1'b0;
  logic       rst;
  logic       digit_valid;
  logic [3:0] digit;
  logic       limpa;
  logic       enable;
  logic [3:0] min_dez, min_uni, seg_dez, seg_uni;
  logic       zero, rodando, tdone;

  typedef struct packed {
    logic [15:0] disp;
    logic        z;
    logic        td;
    logic        rd;
  } obs_t;

  obs_t  exp_q[$];
  string name_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  obs_t  e_m, a_m;
  string nm_m;

  contador_tempo_bcd #(.TICK_DIV(4), .PRESC_W(3)) dut (
    .clk(clk), .rst(rst), .digit_valid(digit_valid), .digit(digit),
    .limpa(limpa), .enable(enable),
    .min_dez(min_dez), .min_uni(min_uni), .seg_dez(seg_dez), .seg_uni(seg_uni),
    .zero(zero), .rodando(rodando), .tdone(tdone)
  );

  always #5 clk = ~clk;

  // monitor: compares every pending expectation on the falling edge
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      e_m  = exp_q.pop_front();
      nm_m = name_q.pop_front();
      a_m  = {min_dez, min_uni, seg_dez, seg_uni, zero, tdone, rodando};
      n_checks++;
      if (a_m !== e_m) begin
        n_fail++;
        $display("FAIL %s: got disp=%h zero=%b tdone=%b rodando=%b, want disp=%h zero=%b tdone=%b rodando=%b",
                 nm_m, a_m.disp, a_m.z, a_m.td, a_m.rd, e_m.disp, e_m.z, e_m.td, e_m.rd);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string nm, input logic [15:0] d, input logic td, input logic rd);
    obs_t e;
    e.disp = d;
    e.z    = (d == 16'h0000);
    e.td   = td;
    e.rd   = rd;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic key(input logic [3:0] d);
    digit_valid = 1'b1;
    digit       = d;
    step(1);
    digit_valid = 1'b0;
    digit       = 4'd0;
  endtask

  task automatic clear();
    limpa = 1'b1;
    step(1);
    limpa = 1'b0;
  endtask

  initial begin
    rst = 1'b1; digit_valid = 1'b0; digit = 4'd0; limpa = 1'b0; enable = 1'b0;
    step(2);
    chk("reset_state", 16'h0000, 1'b0, 1'b0);
    rst = 1'b0;
    step(1);

    // keypad entry
    key(4'd1);
    chk("entry_first", 16'h0001, 1'b0, 1'b0);
    key(4'd2); key(4'd3); key(4'd4); key(4'd5);
    chk("entry_shift", 16'h2345, 1'b0, 1'b0);
    key(4'd12);
    chk("entry_invalid", 16'h2345, 1'b0, 1'b0);
    clear();
    chk("limpa_clear", 16'h0000, 1'b0, 1'b0);

    // countdown with borrows from 01:00
    key(4'd1); key(4'd0); key(4'd0);
    chk("load_0100", 16'h0100, 1'b0, 1'b0);
    enable = 1'b1;
    step(1);
    chk("run_start", 16'h0100, 1'b0, 1'b1);
    step(3);
    chk("pre_tick", 16'h0100, 1'b0, 1'b1);
    step(1);
    chk("tick_0059", 16'h0059, 1'b0, 1'b1);
    step(4);
    chk("tick_0058", 16'h0058, 1'b0, 1'b1);
    enable = 1'b0;
    step(1);
    chk("pause_enter", 16'h0058, 1'b0, 1'b0);
    clear();

    // 00:10 -> 00:09
    key(4'd1); key(4'd0);
    enable = 1'b1;
    step(5);
    chk("tick_0009", 16'h0009, 1'b0, 1'b1);
    enable = 1'b0;
    step(1);
    clear();

    // pause two cycles into a second, then resume
    key(4'd3);
    enable = 1'b1;
    step(1);
    chk("run_0003", 16'h0003, 1'b0, 1'b1);
    step(2);
    enable = 1'b0;
    step(1);
    chk("pause_0003", 16'h0003, 1'b0, 1'b0);
    step(9);
    chk("pause_hold", 16'h0003, 1'b0, 1'b0);
    enable = 1'b1;
    step(1);
    chk("resume_1", 16'h0003, 1'b0, 1'b1);
    step(1);
    chk("resume_tick", 16'h0002, 1'b0, 1'b1);

    // run to completion
    step(3);
    chk("hold_0002", 16'h0002, 1'b0, 1'b1);
    step(1);
    chk("tick_0001", 16'h0001, 1'b0, 1'b1);
    step(3);
    chk("hold_0001", 16'h0001, 1'b0, 1'b1);
    step(1);
    chk("done_edge", 16'h0000, 1'b1, 1'b0);
    step(5);
    chk("done_hold", 16'h0000, 1'b1, 1'b0);
    enable = 1'b0;
    key(4'd7);
    chk("done_digit", 16'h0007, 1'b0, 1'b0);
    step(2);
    chk("entry_idle", 16'h0007, 1'b0, 1'b0);

    // limpa wins over a same-cycle digit; zero count does not start
    clear();
    key(4'd1); key(4'd2);
    chk("load_0012", 16'h0012, 1'b0, 1'b0);
    limpa = 1'b1; digit_valid = 1'b1; digit = 4'd5;
    step(1);
    limpa = 1'b0; digit_valid = 1'b0; digit = 4'd0;
    chk("limpa_vs_digit", 16'h0000, 1'b0, 1'b0);
    enable = 1'b1;
    step(3);
    chk("zero_no_run", 16'h0000, 1'b0, 1'b0);
    enable = 1'b0;

    // asynchronous reset in the middle of a run
    key(4'd1); key(4'd2); key(4'd3);
    enable = 1'b1;
    step(1);
    chk("run_0123", 16'h0123, 1'b0, 1'b1);
    step(2);
    #1 rst = 1'b1;
    #1 chk("reset_async", 16'h0000, 1'b0, 1'b0);
    step(1);
    rst = 1'b0;
    enable = 1'b0;
    key(4'd4);
    chk("post_reset_entry", 16'h0004, 1'b0, 1'b0);
    step(2);

    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations never checked, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/contador_tempo_bcd.md
Name: contador_tempo_bcd

Overview:
- Countdown timer for the microwave, directly upstream of the Set/Reset control logic.
- Accepts keypad digits into a 4-digit BCD MM:SS register.
- Counts down once per second while the magnetron is enabled, pauses while it is disabled, and raises tdone at 00:00.
- tdone feeds the control logic's tdone input, which forces Reset of the magnetron latch.

Parameters:
- TICK_DIV, 50_000_000: clk cycles per one-second decrement. Benches use 4.
- PRESC_W, 26: prescaler width. Must satisfy 2^PRESC_W >= TICK_DIV.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- digit_valid  in  1  one-cycle strobe: keypad digit present.
- digit  in  4  BCD keypad digit. Values 10-15 are ignored.
- limpa  in  1  clear request, level.
- enable  in  1  magnetron-on level from the Set/Reset latch output.
- min_dez  out  4  BCD minutes tens.
- min_uni  out  4  BCD minutes ones.
- seg_dez  out  4  BCD seconds tens.
- seg_uni  out  4  BCD seconds ones.
- zero  out  1  combinational: all four digits are 0.
- rodando  out  1  high while state=RUN.
- tdone  out  1  registered: countdown finished.

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is asynchronous and active-high.
- rst asserted: state=ENTRY, all digits 0, prescaler 0, tdone 0, rodando 0. Applies immediately, including mid-run.
- States: ENTRY, RUN, PAUSE, DONE. All registered; transitions take effect on the next rising edge.
- Priority each cycle: limpa > digit_valid > enable/tick.
- limpa=1 in any state:
  - Next state ENTRY; digits cleared to 0000; prescaler 0; tdone 0.
  - A simultaneous digit_valid is dropped.
- ENTRY:
  - digit_valid with digit<=9 shifts left: min_dez<=min_dez... more precisely min_dez<=min_uni, min_uni<=seg_dez, seg_dez<=seg_uni, seg_uni<=digit. The old min_dez is discarded.
  - digit>9 is ignored.
  - enable=1 and count nonzero (checked after any shift in the same cycle is not applied; the current count is used) -> RUN, prescaler 0.
  - enable=1 and count zero -> stay in ENTRY.
- RUN:
  - Prescaler increments each cycle enable=1.
  - At prescaler==TICK_DIV-1 with enable=1: prescaler<=0 and the count decrements by one second. The first decrement therefore occurs TICK_DIV cycles after entering RUN.
  - If that decrement yields 0000: next state DONE, tdone<=1 on the same edge, so tdone rises together with the 00:00 display.
  - enable=0 -> PAUSE. The prescaler holds its value and no decrement happens that cycle, even at terminal count.
  - digit_valid is ignored.
- PAUSE:
  - Count and prescaler frozen; digit_valid ignored.
  - enable=1 -> RUN, resuming from the held prescaler value (partial seconds are preserved).
- DONE:
  - tdone=1; count stays 0000; enable is ignored.
  - digit_valid with a valid digit: tdone<=0, digits become 000d, next state ENTRY.
  - limpa -> ENTRY.
- BCD decrement rules:
  - seg_uni>0: seg_uni-1.
  - Otherwise seg_uni<=9 with a borrow into seg_dez.
  - seg_dez>0: seg_dez-1.
  - Otherwise seg_dez<=5 with a borrow into min_uni.
  - min_uni>0: min_uni-1.
  - Otherwise min_uni<=9 and min_dez-1.
  - The decrement is never applied at 0000, so there is no wrap to 99:59.
- Entered seconds tens of 6-9 are legal (e.g. 0:90 = 90 s). They decrement naturally, and a borrow always reloads 5.
- Count of 99:99 is legal. All four digits always hold a value <=9.
- rodando = (state==RUN), registered with the state.

Test Plan:
- Reset: rst pulse mid-RUN at count 01:23 -> outputs 00:00 immediately, tdone 0, rodando 0, state ENTRY.
- Entry: strobe digits 1,2,3,4,5 plus digit 12 (invalid) -> display 23:45 (12 ignored, leading 1 shifted out). Then limpa -> 00:00.
- Countdown with borrows, TICK_DIV=4: enter 1,0,0, enable=1 -> rodando next cycle; after 4 cycles shows 00:59, after 8 cycles 00:58. Enter 0:10 separately -> after one tick 00:09.
- Pause/resume: count 00:03, enable dropped 2 cycles into a second, held 10 cycles -> display unchanged at 00:03. Re-enable -> decrement to 00:02 exactly 2 cycles later.
- Finish: 00:02 running -> reaches 00:00 with tdone=1 on the same edge. tdone stays high with enable held 1. Digit 7 -> tdone 0, display 00:07, state ENTRY.
- Simultaneous: limpa and digit_valid(5) in the same cycle during ENTRY at 00:12 -> 00:00. enable=1 with count 0000 -> rodando stays 0.
